// File: rtl/alu_ctrl_seq_if.sv
// rtl/alu_ctrl_seq_if.sv - decode request and ALU control beat handshake bundle
interface alu_ctrl_seq_if #(
    parameter int FUNC_W = 4,
    parameter int CODE_W = 3,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        opcode;
    logic [FUNC_W-1:0] func;
    logic [CNT_W-1:0]  count;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] alu_code;
    logic [CNT_W-1:0]  out_step;
    logic              out_last;
    logic              illegal;

    modport master (
        output in_valid, opcode, func, count, out_ready,
        input  in_ready, out_valid, alu_code, out_step, out_last, illegal
    );

    modport slave (
        input  in_valid, opcode, func, count, out_ready,
        output in_ready, out_valid, alu_code, out_step, out_last, illegal
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - instruction decode to sequenced ALU control beats
module alu_ctrl_seq #(
    parameter int FUNC_W = 4,
    parameter int CODE_W = 3,
    parameter int CNT_W  = 4
) (
    input logic          clk,
    input logic          rst,
    alu_ctrl_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, ITER} state_t;

    state_t            state, state_nx;
    logic [CODE_W-1:0] code_q, code_nx;
    logic [CNT_W-1:0]  step_q, step_nx;
    logic [CNT_W-1:0]  last_q, last_nx;
    logic              ill_q, ill_nx;

    logic [CODE_W-1:0] dec_code;
    logic              dec_multi;
    logic              dec_ill;
    logic [CNT_W-1:0]  dec_last;

    logic valid, last, ready, accept, consume;

    always_comb begin
        dec_code  = '0;
        dec_multi = 1'b0;
        dec_ill   = 1'b0;
        case (bus.opcode)
            3'b000: begin
                if (bus.func < FUNC_W'(8)) begin
                    dec_code = CODE_W'(bus.func[2:0]);
                end else if (bus.func == FUNC_W'(8)) begin
                    dec_code  = CODE_W'(3'b010);
                    dec_multi = 1'b1;
                end else if (bus.func == FUNC_W'(9)) begin
                    dec_multi = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            3'b001, 3'b011, 3'b100: dec_code = '0;
            3'b010, 3'b110:         dec_code = CODE_W'(3'b001);
            default:                dec_ill  = 1'b1;
        endcase
    end

    // Index of the final beat; a zero count still yields one beat.
    assign dec_last = (dec_multi && bus.count != '0) ? bus.count - CNT_W'(1) : '0;

    assign valid   = (state != IDLE);
    assign last    = (state == ISSUE);
    assign ready   = !rst && (!valid || (bus.out_ready && last));
    assign accept  = bus.in_valid && ready;
    assign consume = valid && bus.out_ready;

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out_last  = last;
    assign bus.alu_code  = code_q;
    assign bus.out_step  = step_q;
    assign bus.illegal   = ill_q;

    always_comb begin
        state_nx = state;
        code_nx  = code_q;
        step_nx  = step_q;
        last_nx  = last_q;
        ill_nx   = ill_q;
        if (accept) begin
            code_nx  = dec_code;
            ill_nx   = dec_ill;
            step_nx  = '0;
            last_nx  = dec_last;
            state_nx = (dec_last == '0) ? ISSUE : ITER;
        end else if (consume) begin
            if (state == ITER) begin
                step_nx  = step_q + CNT_W'(1);
                state_nx = (step_q + CNT_W'(1) == last_q) ? ISSUE : ITER;
            end else begin
                state_nx = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            code_q <= '0;
            step_q <= '0;
            last_q <= '0;
            ill_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            code_q <= code_nx;
            step_q <= step_nx;
            last_q <= last_nx;
            ill_q  <= ill_nx;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - scoreboard bench for alu_ctrl_seq with directed vectors
module tb_alu_ctrl_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_ctrl_seq_if #(.FUNC_W(4), .CODE_W(3), .CNT_W(4)) bus ();

    alu_ctrl_seq #(.FUNC_W(4), .CODE_W(3), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0] code;
        logic [3:0] step;
        logic       last;
        logic       ill;
    } beat_t;

    typedef struct {
        logic [2:0] op;
        logic [3:0] fn;
        logic [3:0] cnt;
        logic [2:0] code;
        int         beats;
        logic       ill;
    } vec_t;

    beat_t sb[$];
    vec_t  vt[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got code=%0d step=%0d last=%0d ill=%0d expected no beat",
                         bus.alu_code, bus.out_step, bus.out_last, bus.illegal);
            end else begin
                beat_t e;
                e = sb.pop_front();
                if ({bus.alu_code, bus.out_step, bus.out_last, bus.illegal} !==
                    {e.code, e.step, e.last, e.ill}) begin
                    bad++;
                    $display("FAIL beat: got code=%0d step=%0d last=%0d ill=%0d expected code=%0d step=%0d last=%0d ill=%0d",
                             bus.alu_code, bus.out_step, bus.out_last, bus.illegal,
                             e.code, e.step, e.last, e.ill);
                end
            end
        end
    end

    task automatic push_op(input logic [2:0] code, input int nbeats, input logic ill);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.code = code;
            b.step = 4'(i);
            b.last = (i == nbeats - 1);
            b.ill  = ill;
            sb.push_back(b);
        end
    endtask

    task automatic send(input vec_t v, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        bus.in_valid = 1'b1;
        bus.opcode   = v.op;
        bus.func     = v.fn;
        bus.count    = v.cnt;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                push_op(v.code, v.beats, v.ill);
                @(posedge clk);
                #1;
                acc = cyc;
                got = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        bus.opcode   = 3'b101;
        bus.func     = 4'hF;
        bus.count    = 4'hF;
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) begin
            @(posedge clk);
            #2;
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #2;
        check("idle_after_op", int'(bus.out_valid), 0);
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [3:0] fn, input logic [3:0] cnt,
                                input logic [2:0] code, input int beats, input logic ill);
        vec_t v;
        v.op = op; v.fn = fn; v.cnt = cnt; v.code = code; v.beats = beats; v.ill = ill;
        return v;
    endfunction

    task automatic check_regs(input string tag, input int v, input int c, input int s,
                              input int l, input int il, input int r);
        check({tag, "_valid"}, int'(bus.out_valid), v);
        check({tag, "_code"},  int'(bus.alu_code),  c);
        check({tag, "_step"},  int'(bus.out_step),  s);
        check({tag, "_last"},  int'(bus.out_last),  l);
        check({tag, "_ill"},   int'(bus.illegal),   il);
        check({tag, "_ready"}, int'(bus.in_ready),  r);
    endtask

    initial begin
        int acc, acc2, rc;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.opcode    = 3'b000;
        bus.func      = 4'h0;
        bus.count     = 4'h0;
        #1;
        check_regs("reset", 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rc  = cyc;
        send(mk(3'b000, 4'h7, 4'h3, 3'b111, 1, 1'b0), acc);
        check("first_accept_edge", acc - rc, 1);
        check_regs("xor_beat", 1, 7, 0, 1, 0, 1);
        wait_drain();

        vt.push_back(mk(3'b000, 4'h0, 4'h5, 3'b000, 1, 1'b0));
        vt.push_back(mk(3'b000, 4'h1, 4'h0, 3'b001, 1, 1'b0));
        vt.push_back(mk(3'b000, 4'h2, 4'h0, 3'b010, 1, 1'b0));
        vt.push_back(mk(3'b000, 4'h3, 4'h0, 3'b011, 1, 1'b0));
        vt.push_back(mk(3'b000, 4'h4, 4'h0, 3'b100, 1, 1'b0));
        vt.push_back(mk(3'b000, 4'h5, 4'h0, 3'b101, 1, 1'b0));
        vt.push_back(mk(3'b000, 4'h6, 4'h0, 3'b110, 1, 1'b0));
        vt.push_back(mk(3'b001, 4'h9, 4'h4, 3'b000, 1, 1'b0));
        vt.push_back(mk(3'b010, 4'h0, 4'h4, 3'b001, 1, 1'b0));
        vt.push_back(mk(3'b011, 4'h8, 4'h0, 3'b000, 1, 1'b0));
        vt.push_back(mk(3'b100, 4'h0, 4'h2, 3'b000, 1, 1'b0));
        vt.push_back(mk(3'b110, 4'h3, 4'h0, 3'b001, 1, 1'b0));
        vt.push_back(mk(3'b101, 4'h0, 4'h5, 3'b000, 1, 1'b1));
        vt.push_back(mk(3'b000, 4'hA, 4'h5, 3'b000, 1, 1'b1));
        vt.push_back(mk(3'b000, 4'hF, 4'h5, 3'b000, 1, 1'b1));
        vt.push_back(mk(3'b000, 4'h8, 4'h1, 3'b010, 1, 1'b0));
        vt.push_back(mk(3'b000, 4'h9, 4'h0, 3'b000, 1, 1'b0));
        vt.push_back(mk(3'b000, 4'h9, 4'h4, 3'b000, 4, 1'b0));
        vt.push_back(mk(3'b000, 4'h8, 4'hF, 3'b010, 15, 1'b0));
        foreach (vt[i]) begin
            send(vt[i], acc);
            wait_drain();
        end

        send(mk(3'b000, 4'h8, 4'h3, 3'b010, 3, 1'b0), acc);
        @(negedge clk);
        check("lslm3_s0_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        check("lslm3_s1_step", int'(bus.out_step), 1);
        @(negedge clk);
        check("lslm3_s2_last", int'(bus.out_last), 1);
        check("lslm3_s2_ready", int'(bus.in_ready), 1);
        wait_drain();

        bus.out_ready = 1'b0;
        send(mk(3'b000, 4'h9, 4'h2, 3'b000, 2, 1'b0), acc);
        bus.in_valid = 1'b1;
        bus.opcode   = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_regs("stall", 1, 0, 0, 0, 0, 0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();

        send(mk(3'b111, 4'h0, 4'h0, 3'b000, 1, 1'b1), acc);
        send(mk(3'b110, 4'h0, 4'h0, 3'b001, 1, 1'b0), acc2);
        check("b2b_no_bubble", acc2 - acc, 1);
        wait_drain();

        send(mk(3'b000, 4'h8, 4'h5, 3'b010, 5, 1'b0), acc);
        @(negedge clk);
        @(negedge clk);
        check("abort_at_step1", int'(bus.out_step), 1);
        #1;
        rst = 1'b1;
        #1;
        check_regs("async_rst", 0, 0, 0, 0, 0, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_abort_quiet", int'(bus.out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(mk(3'b010, 4'h0, 4'h0, 3'b001, 1, 1'b0), acc);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
